// File: rtl/uart_rx_stream_pkg.sv
// uart_pkg: shared definitions for the uart_rx_stream receiver slice.
//   - uart_state_e : receiver FSM state encoding
//   - uart_dbg_t   : debug snapshot of the FSM (state, oversample phase, bit index)
//   - register offsets on the CPU bus and bit positions inside the status word
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  typedef struct packed {
    uart_state_e state;
    logic [3:0]  sub;
    logic [2:0]  bitn;
  } uart_dbg_t;

  // CPU register offsets (bus address a)
  localparam logic [2:0] UART_DATA = 3'd0;
  localparam logic [2:0] UART_STAT = 3'd1;

  // Status word bit positions
  localparam int AVAIL = 0;
  localparam int FERR  = 1;
  localparam int OVR   = 2;

  // Three-sample majority vote used for every bit decision.
  function automatic logic maj3(input logic s0, input logic s1, input logic s2);
    return (s0 & s1) | (s0 & s2) | (s1 & s2);
  endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// uart_rx_stream_if: groups the receiver's byte stream and CPU register bus.
//
// Handshake semantics (one rule for the whole interface):
//   uart_ready is a one-cycle strobe with no back-pressure; uart_data is valid
//   in the strobe cycle and stays stable until the next good byte. The CPU bus
//   never stalls: ready is constant 1, spo is combinational from a, and we/rd
//   are single-cycle strobes that take effect at the next clk edge.
//
// Signals:
//   uart_data  [7:0]  last good byte           (slave -> master)
//   uart_ready        byte strobe              (slave -> master)
//   a          [2:0]  register address         (master -> slave)
//   d          [31:0] write data               (master -> slave)
//   we, rd            write / read strobes     (master -> slave)
//   spo        [31:0] read data                (slave -> master)
//   ready             always 1                 (slave -> master)
//   dbg               FSM debug snapshot       (slave -> master)
interface uart_rx_stream_if;
  import uart_pkg::*;

  logic [7:0]  uart_data;
  logic        uart_ready;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready;
  uart_dbg_t   dbg;

  modport slave (
    input  a, d, we, rd,
    output uart_data, uart_ready, spo, ready, dbg
  );

  modport master (
    output a, d, we, rd,
    input  uart_data, uart_ready, spo, ready, dbg
  );

endinterface

// File: rtl/uart_rx_stream_baud_tick.sv
// uart_baud_tick: oversample tick generator.
// Free-running counter 0..DIV-1; o_tick is high in the cycle the count is DIV-1.
// i_restart synchronously forces the count back to 0 so the first oversample
// period of a frame is aligned to the detected start edge.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_restart  restart the count at 0 on the next edge
//   o_tick     one-cycle oversample tick
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_last;

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 16x oversampled UART receiver feeding the boot loader byte
// stream and a small CPU register block.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   rx         asynchronous serial input, idle high
//   bus        uart_rx_stream_if.slave: byte stream (uart_data/uart_ready),
//              CPU bus (a, d, we, rd, spo, ready) and FSM debug snapshot
// Register map: a=0 read data (rd clears avail); a=1 status
// {overrun, frame_err, avail}, write-1-to-clear on bits 1 and 2.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 62500000,
  parameter int BAUD     = 115200
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_stream_if.slave bus
);

  localparam int DIV_RAW = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

  uart_state_e r_state, w_next;

  logic       r_rx_m, r_rx_s;
  logic [3:0] r_sub;
  logic [2:0] r_bitn;
  logic [7:0] r_shreg;
  logic       r_v7, r_v8, r_v9;
  logic [7:0] r_uart_data;
  logic       r_uart_ready;
  logic       r_avail, r_ferr, r_ovr;

  logic w_tick, w_restart, w_vote, w_v9;
  logic w_bit_end, w_stop_eval, w_shift, w_latch, w_ferr_set;
  logic w_rd_data, w_w1c;
  logic w_unused_d;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // The stop bit is decided at sub=9, before the third sample is registered,
  // so the live synchronized value stands in for it there.
  assign w_v9   = (r_sub == 4'd9) ? r_rx_s : r_v9;
  assign w_vote = maj3(r_v7, r_v8, w_v9);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // FSM: next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!r_rx_s) w_next = ST_START;
      ST_START: if (w_tick && r_sub == 4'd15) w_next = w_vote ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_tick && r_sub == 4'd15 && r_bitn == 3'd7) w_next = ST_STOP;
      ST_STOP:  if (w_tick && r_sub == 4'd9) w_next = w_vote ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (r_rx_s) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM: output/control decode
  always_comb begin
    w_restart   = 1'b0;
    w_bit_end   = 1'b0;
    w_stop_eval = 1'b0;
    case (r_state)
      ST_IDLE:  w_restart   = !r_rx_s;
      ST_START,
      ST_DATA:  w_bit_end   = w_tick && (r_sub == 4'd15);
      ST_STOP:  w_stop_eval = w_tick && (r_sub == 4'd9);
      default:  ;
    endcase
  end

  assign w_shift    = w_bit_end && (r_state == ST_DATA);
  assign w_latch    = w_stop_eval && w_vote;
  assign w_ferr_set = w_stop_eval && !w_vote;

  assign w_rd_data = bus.rd && (bus.a == UART_DATA);
  assign w_w1c     = bus.we && (bus.a == UART_STAT);

  // Frame datapath: oversample phase, bit index, samples, shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub   <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
      r_v7    <= 1'b1;
      r_v8    <= 1'b1;
      r_v9    <= 1'b1;
    end else begin
      if (r_state == ST_IDLE || r_state == ST_BREAK) begin
        r_sub <= '0;
      end else if (w_tick) begin
        r_sub <= r_sub + 4'd1;
        if (r_sub == 4'd7) r_v7 <= r_rx_s;
        if (r_sub == 4'd8) r_v8 <= r_rx_s;
        if (r_sub == 4'd9) r_v9 <= r_rx_s;
      end

      if (r_state == ST_START)  r_bitn <= '0;
      else if (w_shift)         r_bitn <= r_bitn + 3'd1;

      if (w_shift) r_shreg[r_bitn] <= w_vote;
    end
  end

  // Byte output and sticky status. A same-cycle data read keeps avail set
  // and suppresses overrun; a new error beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_uart_data  <= '0;
      r_uart_ready <= 1'b0;
      r_avail      <= 1'b0;
      r_ferr       <= 1'b0;
      r_ovr        <= 1'b0;
    end else begin
      r_uart_ready <= w_latch;
      if (w_latch) r_uart_data <= r_shreg;

      if (w_latch)        r_avail <= 1'b1;
      else if (w_rd_data) r_avail <= 1'b0;

      if (w_latch && r_avail && !w_rd_data) r_ovr <= 1'b1;
      else if (w_w1c && bus.d[OVR])         r_ovr <= 1'b0;

      if (w_ferr_set)                  r_ferr <= 1'b1;
      else if (w_w1c && bus.d[FERR])   r_ferr <= 1'b0;
    end
  end

  always_comb begin
    bus.spo = '0;
    case (bus.a)
      UART_DATA: bus.spo = {24'b0, r_uart_data};
      UART_STAT: bus.spo = {29'b0, r_ovr, r_ferr, r_avail};
      default:   bus.spo = '0;
    endcase
  end

  assign bus.uart_data  = r_uart_data;
  assign bus.uart_ready = r_uart_ready;
  assign bus.ready      = 1'b1;
  assign bus.dbg        = '{state: r_state, sub: r_sub, bitn: r_bitn};

  // Write data bits with no register behind them.
  assign w_unused_d = &{1'b0, bus.d[31:3], bus.d[0]};

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed testbench for uart_rx_stream at 16 clocks per bit (DIV=1).
module tb_uart_rx_stream;
  import uart_pkg::*;

  localparam int BIT_CLKS = 16;

  logic clk;
  logic rst;
  logic rx;

  uart_rx_stream_if bus ();

  uart_rx_stream #(
    .CLK_FREQ (1600000),
    .BAUD     (100000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_strobes = 0;
  logic [7:0] exp_q[$];
  logic prev_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Strobe monitor: every strobe must be expected, carry the right byte and
  // last exactly one cycle.
  always @(negedge clk) begin
    if (prev_ready) chk("strobe_one_cycle", {31'b0, bus.uart_ready}, 32'd0);
    if (bus.uart_ready && !prev_ready) begin
      n_strobes++;
      chk("strobe_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("strobe_data", {24'b0, bus.uart_data}, {24'b0, exp_q.pop_front()});
    end
    prev_ready = bus.uart_ready;
  end

  // ---------------- driver tasks (called and returning at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic cpu_read(input logic [2:0] addr, output logic [31:0] data);
    bus.a  = addr;
    bus.rd = 1'b1;
    #1 data = bus.spo;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic cpu_write(input logic [2:0] addr, input logic [31:0] val);
    bus.a  = addr;
    bus.d  = val;
    bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
    bus.d  = '0;
  endtask

  task automatic peek_status(output logic [31:0] data);
    bus.a = UART_STAT;
    #1 data = bus.spo;
  endtask

  // Wait (bounded) until the FSM is in want_state and, depending on
  // use_bitn, sub or bitn equals val.
  task automatic wait_dbg(input string tag, input uart_state_e want_state,
                          input logic use_bitn, input logic [3:0] val);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (bus.dbg.state == want_state &&
          (use_bitn ? ({1'b0, bus.dbg.bitn} == val) : (bus.dbg.sub == val))) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, {31'b0, found}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] rdata;
  int strobes_before;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    bus.a = '0; bus.d = '0; bus.we = 1'b0; bus.rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_uart_data", {24'b0, bus.uart_data}, 32'h0);
    chk("rst_uart_ready", {31'b0, bus.uart_ready}, 32'h0);
    chk("rst_bus_ready", {31'b0, bus.ready}, 32'h1);
    chk("rst_state", {29'b0, bus.dbg.state}, {29'b0, ST_IDLE});
    peek_status(rdata);
    chk("rst_status", rdata, 32'h0);
    repeat (4) @(negedge clk);

    // Clean byte 0x35
    exp_q.push_back(8'h35);
    send_byte(8'h35, 1'b1);
    repeat (8) @(negedge clk);
    chk("clean_strobes", 32'(n_strobes), 32'd1);
    cpu_read(UART_STAT, rdata);
    chk("clean_status", rdata, 32'h1);
    cpu_read(UART_DATA, rdata);
    chk("clean_data_read", rdata, 32'h35);
    cpu_read(UART_STAT, rdata);
    chk("clean_status_after_rd", rdata, 32'h0);

    // Back-to-back "3a " with no idle gap, no CPU reads
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h20);
    send_byte(8'h33, 1'b1);
    send_byte(8'h61, 1'b1);
    send_byte(8'h20, 1'b1);
    repeat (8) @(negedge clk);
    chk("b2b_strobes", 32'(n_strobes), 32'd4);
    chk("b2b_data_held", {24'b0, bus.uart_data}, 32'h20);
    cpu_read(UART_STAT, rdata);
    chk("b2b_status_ovr", rdata, 32'h5);
    cpu_read(UART_DATA, rdata);
    cpu_write(UART_STAT, 32'h4);
    cpu_read(UART_STAT, rdata);
    chk("b2b_status_cleared", rdata, 32'h0);

    // Glitch: 4 clocks low
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_state", {29'b0, bus.dbg.state}, {29'b0, ST_IDLE});
    chk("glitch_strobes", 32'(n_strobes), 32'd4);
    cpu_read(UART_STAT, rdata);
    chk("glitch_status", rdata, 32'h0);

    // Framing error: 0x41 with stop bit 0, then line held low for 40 bits
    send_byte(8'h41, 1'b0);
    repeat (40 * BIT_CLKS) @(negedge clk);
    chk("ferr_break_state", {29'b0, bus.dbg.state}, {29'b0, ST_BREAK});
    rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("ferr_idle_state", {29'b0, bus.dbg.state}, {29'b0, ST_IDLE});
    chk("ferr_strobes", 32'(n_strobes), 32'd4);
    cpu_read(UART_STAT, rdata);
    chk("ferr_status", rdata, 32'h2);
    cpu_write(UART_STAT, 32'h2);
    cpu_read(UART_STAT, rdata);
    chk("ferr_w1c", rdata, 32'h0);

    // Collision: data read in the same cycle as the second byte's latch
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    cpu_read(UART_STAT, rdata);
    chk("coll_first_status", rdata, 32'h1);
    exp_q.push_back(8'hC3);
    fork
      send_byte(8'hC3, 1'b1);
      begin
        wait_dbg("coll_reach_stop", ST_STOP, 1'b0, 4'd9);
        bus.a  = UART_DATA;
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    cpu_read(UART_STAT, rdata);
    chk("coll_status", rdata, 32'h1);
    chk("coll_data", {24'b0, bus.uart_data}, 32'hC3);

    // Mid-frame reset during DATA bit 4 (0xF3 keeps the line high from bit 4 on)
    strobes_before = n_strobes;
    fork
      send_byte(8'hF3, 1'b1);
      begin
        wait_dbg("mid_reach_bit4", ST_DATA, 1'b1, 4'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (8) @(negedge clk);
    chk("mid_no_strobe", 32'(n_strobes), 32'(strobes_before));
    cpu_read(UART_STAT, rdata);
    chk("mid_status_reset", rdata, 32'h0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    repeat (8) @(negedge clk);
    chk("mid_one_strobe", 32'(n_strobes), 32'(strobes_before + 1));
    chk("mid_data", {24'b0, bus.uart_data}, 32'h7E);
    cpu_read(UART_STAT, rdata);
    chk("mid_status", rdata, 32'h1);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- Serial receiver that feeds the boot loader's byte stream (`uart_data` / `uart_ready`) and the CPU's UART read registers.
- Sits between the board RX pin and both the serial-boot loader and the CPU bus decode.
- Oversamples the line 16x and majority-votes each bit.
- Presents each received byte as held data plus a one-cycle strobe, and keeps sticky framing/overrun status for software.

Parameters:
- CLK_FREQ, 62500000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DIV, CLK_FREQ/(BAUD*16) rounded to nearest, localparam, clocks per oversample tick (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx  in  1  asynchronous serial input, idle high.
- uart_data  out  8  last good byte; held stable until the next good byte.
- uart_ready  out  1  one-cycle pulse; uart_data is valid in that cycle and stays valid afterwards.
- a  in  3  CPU register address.
- d  in  32  CPU write data.
- we  in  1  CPU write strobe, one cycle.
- rd  in  1  CPU read strobe, one cycle.
- spo  out  32  CPU read data, combinational from a.
- ready  out  1  constant 1; accesses never stall.

Behaviour:
- Reset: rst is synchronous, active-high, clock clk. All outputs go to 0 (ready=1). State goes to IDLE. Counters, avail, frame_err and overrun clear. Synchronizer flops are set to 1. Reset mid-frame abandons the frame; no strobe is emitted.
- Input conditioning: rx passes through a 2-flop synchronizer; rx_s is the second flop.
- Tick generator: free-running counter 0..DIV-1. tick=1 when the count is DIV-1. The counter restarts at 0 on entry to START.
- sub: 4-bit tick counter, 0..15 per bit. bitn: 3-bit data bit index.
- Bit sampling: rx_s is sampled at sub=7, 8 and 9. bit = majority of the three.
- FSM:
  - IDLE: when rx_s=0, go to START with sub=0.
  - START: at sub=15 with tick, if the voted bit is 1 (false start, glitch), go to IDLE. Otherwise go to DATA with bitn=0 and sub=0.
  - DATA: at sub=15 with tick, shift the voted bit into shreg[bitn] (LSB first). When bitn=7 go to STOP; otherwise bitn increments.
  - STOP: evaluate at sub=9 with tick (early exit, so back-to-back frames are tolerated).
    - Voted bit 1: next cycle uart_data<=shreg, uart_ready=1 for exactly one cycle. If avail was already 1, set overrun. Set avail. Go to IDLE.
    - Voted bit 0: set frame_err, no strobe, uart_data unchanged, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This covers line break/low lines without generating bytes.
- Latency: uart_ready rises 1 clk after the STOP evaluation tick. Nominal latency is 9.5625 bit times (153 ticks) after the start-bit falling edge, plus 2 synchronizer clocks.
- Register map (a):
  - a=0, read: spo={24'b0,uart_data}. rd clears avail.
  - a=1, read: spo={29'b0,overrun,frame_err,avail}.
  - a=1, write: write-1-to-clear. d[1] clears frame_err; d[2] clears overrun; d[0] is ignored.
  - Other addresses read 0; writes are ignored.
- Simultaneous events:
  - rd at a=0 in the same cycle as a new byte latch: avail stays 1 and overrun is not set.
  - W1C in the same cycle as a new error: set wins.
- uart_ready never pulses on frames with a framing error or on false starts.

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE, START, DATA, STOP, BREAK), register offsets (UART_DATA=0, UART_STAT=1) and status bit positions (AVAIL=0, FERR=1, OVR=2).
- One natural sub-module: uart_baud_tick (counter producing tick from DIV, with a sync restart input).
- The synchronizer stays inline.

Test Plan:
- Clean byte: CLK_FREQ=1600000, BAUD=100000 (DIV=1, 16 clk/bit). Send 0x35 ('5').
  - uart_ready pulses exactly 1 cycle with uart_data=0x35.
  - Status read = 0x1.
  - Data read returns 0x35; a following status read = 0x0.
- Back-to-back: send "3a " with no idle gap.
  - Three strobes with data 0x33, 0x61, 0x20, in order.
  - overrun=1 because there is no CPU read.
  - uart_data holds 0x20 afterwards.
- Glitch: drive rx low for 4 clocks, then high.
  - No strobe; state returns to IDLE; status=0.
- Framing: send 0x41 with stop bit 0, then hold rx low for 40 bits, then release.
  - No strobe; status bit1=1; no byte generated during the low period.
  - Write a=1, d=0x2 → status bit1=0.
- Collision: time a rd at a=0 to the same cycle as the latch of a second byte → status after that cycle = 0x1, overrun=0.
- Mid-frame reset: assert rst during DATA bit 4, then release, then send 0x7E.
  - Only one strobe, data 0x7E; status=0x1.
